// File: rtl/ce_timer_arbiter_pkg.sv
// rtl/ce_timer_arbiter_pkg.sv - shared types, defaults and helpers for the timer arbiter
package ce_timer_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXPIRE
    } t_timer_state;

    // Up to eight requesters; callers zero-extend narrower vectors.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ce_timer_arbiter_rr.sv
// rtl/ce_timer_arbiter_rr.sv - combinational round-robin picker with one-hot result
//
// Ports:
//   i_req   request vector
//   i_last  index of the last owner; the search starts just above it
//   o_grant one-hot winner (zero when no request)
//   o_valid any request present
module rr_arbiter_onehot #(
    parameter int par_num_req = 4
) (
    input  logic [par_num_req-1:0]         i_req,
    input  logic [$clog2(par_num_req)-1:0] i_last,
    output logic [par_num_req-1:0]         o_grant,
    output logic                           o_valid
);

    logic found;

    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        // First pass: indices above the last owner, lowest first.
        for (int i = 0; i < par_num_req; i++) begin
            if (!found && i_req[i] && (i > int'(i_last))) begin
                o_grant[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Second pass wraps around to index 0.
        for (int i = 0; i < par_num_req; i++) begin
            if (!found && i_req[i]) begin
                o_grant[i] = 1'b1;
                found      = 1'b1;
            end
        end
        o_valid = |i_req;
    end

endmodule

// File: rtl/ce_timer_arbiter.sv
// rtl/ce_timer_arbiter.sv - one tick-paced countdown timer shared round-robin among requesters
//
// Ports:
//   i_clk_mhz  system clock
//   i_rst_mhz  synchronous active-high reset
//   i_ce_tick  one-cycle timebase pulse
//   i_req      per-requester request level
//   i_len      flattened tick counts, requester k at [k*W +: W]
//   i_cancel   per-requester abort, only the owner's bit matters
//   o_grant    one-hot current owner
//   o_done     one-cycle expiry pulse to the owner
//   o_busy     timer not idle
//   o_owner    index of the current or last owner
module ce_timer_arbiter
    import ce_timer_arbiter_pkg::*;
#(
    parameter int par_num_req   = DEF_NUM_REQ,
    parameter int par_len_width = DEF_LEN_WIDTH
) (
    input  logic                                 i_clk_mhz,
    input  logic                                 i_rst_mhz,
    input  logic                                 i_ce_tick,
    input  logic [par_num_req-1:0]               i_req,
    input  logic [par_num_req*par_len_width-1:0] i_len,
    input  logic [par_num_req-1:0]               i_cancel,
    output logic [par_num_req-1:0]               o_grant,
    output logic [par_num_req-1:0]               o_done,
    output logic                                 o_busy,
    output logic [$clog2(par_num_req)-1:0]       o_owner
);

    localparam int IDX_W = $clog2(par_num_req);

    t_timer_state             state_q, state_d;
    logic [par_len_width-1:0] cnt_q, cnt_d;
    logic [par_num_req-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         last_q, last_d;

    logic [par_num_req-1:0]   arb_grant;
    logic                     arb_valid;
    logic [par_len_width-1:0] sel_len;
    logic                     owner_cancel;

    rr_arbiter_onehot #(
        .par_num_req (par_num_req)
    ) u_rr (
        .i_req   (i_req),
        .i_last  (last_q),
        .o_grant (arb_grant),
        .o_valid (arb_valid)
    );

    always_comb begin
        sel_len = '0;
        for (int k = 0; k < par_num_req; k++) begin
            if (arb_grant[k]) begin
                sel_len = i_len[k*par_len_width +: par_len_width];
            end
        end
    end

    // grant_q is one-hot, so masking avoids indexing by owner.
    assign owner_cancel = |(i_cancel & grant_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    owner_d = IDX_W'(onehot_to_index(8'(arb_grant)));
                    cnt_d   = sel_len;
                    state_d = (sel_len == '0) ? ST_EXPIRE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Cancel wins over a terminal tick in the same cycle.
                if (owner_cancel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (i_ce_tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == par_len_width'(1)) begin
                        state_d = ST_EXPIRE;
                    end
                end
            end
            ST_EXPIRE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = owner_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(par_num_req - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign o_grant = grant_q;
    assign o_done  = (state_q == ST_EXPIRE) ? grant_q : '0;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_owner = owner_q;

endmodule
